// File: rtl/siren_arbiter.sv
// Priority arbiter sharing one speaker pin among several tone generators.
// Enforces a minimum play time before preemption and a silent gap between grants.
`timescale 1ns/1ps

module siren_arbiter #(
    parameter int unsigned N_SRC       = 4,
    parameter int unsigned HOLD_CYCLES = 1000,
    parameter int unsigned GAP_CYCLES  = 100
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_SRC-1:0] req,
    input  logic [N_SRC-1:0] tone,
    output logic [N_SRC-1:0] grant,
    output logic             speaker,
    output logic             busy
);

    localparam int unsigned HOLD_W = $clog2(HOLD_CYCLES + 1);
    localparam int unsigned GAP_W  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t            state;
    logic [HOLD_W-1:0] hold_cnt;
    logic [GAP_W-1:0]  gap_cnt;

    logic [N_SRC-1:0]  win_c;
    logic              own_drop_c;
    logic              higher_req_c;
    logic              hold_done_c;
    logic              gap_done_c;

    // Lowest set index of req wins; grant-1 masks every index above the owner.
    always_comb begin
        win_c        = req & (~req + N_SRC'(1));
        own_drop_c   = ~|(req & grant);
        higher_req_c = |(req & (grant - N_SRC'(1)));
        hold_done_c  = (hold_cnt == HOLD_W'(HOLD_CYCLES));
        gap_done_c   = (gap_cnt == GAP_W'(GAP_CYCLES - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            grant    <= '0;
            speaker  <= 1'b0;
            busy     <= 1'b0;
            hold_cnt <= '0;
            gap_cnt  <= '0;
        end else begin
            // Uses the pre-edge grant, so the speaker trails grant by one cycle.
            speaker <= (state == PLAY) && (|(tone & grant));
            case (state)
                IDLE: begin
                    if (|req) begin
                        state    <= PLAY;
                        grant    <= win_c;
                        hold_cnt <= '0;
                        busy     <= 1'b1;
                    end else begin
                        busy <= 1'b0;
                    end
                end
                PLAY: begin
                    busy <= 1'b1;
                    if (!hold_done_c) begin
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                    end
                    if (own_drop_c || (higher_req_c && hold_done_c)) begin
                        state   <= GAP;
                        grant   <= '0;
                        gap_cnt <= '0;
                    end
                end
                GAP: begin
                    // Requests are only looked at on the last gap cycle.
                    if (gap_done_c) begin
                        gap_cnt <= '0;
                        if (|req) begin
                            state    <= PLAY;
                            grant    <= win_c;
                            hold_cnt <= '0;
                            busy     <= 1'b1;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                        busy    <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    grant <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_siren_arbiter.sv
// Self-checking bench for siren_arbiter: directed scenarios plus random
// request traffic compared against an owner/age/gap reference model.
`timescale 1ns/1ps

module tb_siren_arbiter;

    localparam int N = 4;
    localparam int H = 8;
    localparam int G = 4;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b1;
    logic [N-1:0] req   = '0;
    logic [N-1:0] tone  = '0;
    logic [N-1:0] grant;
    logic         speaker;
    logic         busy;

    int tests = 0;
    int fails = 0;
    int tcnt[N] = '{default: 0};

    siren_arbiter #(.N_SRC(N), .HOLD_CYCLES(H), .GAP_CYCLES(G)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .tone(tone),
        .grant(grant), .speaker(speaker), .busy(busy)
    );

    always #5 clk = ~clk;

    // tone[i] is clk divided by 2(i+1)
    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (tcnt[i] == i) begin
                tcnt[i] <= 0;
                tone[i] <= ~tone[i];
            end else begin
                tcnt[i] <= tcnt[i] + 1;
            end
        end
    end

    // Reference model: who owns the speaker, how long it has played,
    // and how many gap edges have elapsed (-1 when not in a gap).
    int   m_owner = -1;
    int   m_age   = 0;
    int   m_gap   = -1;
    logic m_spk   = 1'b0;
    logic m_busy  = 1'b0;

    function automatic int lowest(input logic [N-1:0] r);
        for (int i = N - 1; i >= 0; i--) if (r[i]) lowest = i;
        if (r == '0) lowest = -1;
    endfunction

    function automatic bit any_higher(input logic [N-1:0] r, input int o);
        any_higher = 1'b0;
        for (int i = 0; i < o; i++) if (r[i]) any_higher = 1'b1;
    endfunction

    function automatic logic [N-1:0] m_grant();
        m_grant = (m_owner >= 0) ? N'(1 << m_owner) : '0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_owner <= -1; m_age <= 0; m_gap <= -1; m_spk <= 1'b0; m_busy <= 1'b0;
        end else begin
            m_spk <= (m_owner >= 0) ? tone[m_owner] : 1'b0;
            if (m_owner >= 0) begin
                if (!req[m_owner] || (any_higher(req, m_owner) && m_age >= H)) begin
                    m_owner <= -1; m_gap <= 0; m_busy <= 1'b1;
                end else begin
                    m_age <= m_age + 1;
                end
            end else if (m_gap >= 0) begin
                if (m_gap == G - 1) begin
                    m_gap   <= -1;
                    m_owner <= lowest(req);
                    m_age   <= 0;
                    m_busy  <= (req != '0);
                end else begin
                    m_gap <= m_gap + 1;
                end
            end else if (req != '0) begin
                m_owner <= lowest(req); m_age <= 0; m_busy <= 1'b1;
            end else begin
                m_busy <= 1'b0;
            end
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic go_idle();
        req = '0;
        repeat (H + G + 4) cycle();
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL idle_busy got=%b want=0", busy); end
        tests++; if (grant !== '0) begin fails++; $display("FAIL idle_grant got=%b want=0000", grant); end
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        req = 4'b0001;
        #1;
        tests++; if ({grant, speaker, busy} !== '0) begin fails++; $display("FAIL reset_init got=%b/%b/%b want=0", grant, speaker, busy); end
        repeat (2) cycle();
        tests++; if ({grant, speaker, busy} !== '0) begin fails++; $display("FAIL reset_held got=%b/%b/%b want=0", grant, speaker, busy); end
        rst_n = 1'b1;
        cycle();
        tests++; if (grant !== 4'b0001 || busy !== 1'b1) begin fails++; $display("FAIL reset_first_grant got=%b busy=%b want=0001 busy=1", grant, busy); end
        repeat (3) cycle();
        #2 rst_n = 1'b0;
        #1;
        tests++; if ({grant, speaker, busy} !== '0) begin fails++; $display("FAIL reset_mid_play got=%b/%b/%b want=0", grant, speaker, busy); end
        #2 rst_n = 1'b1;
        cycle();
        tests++; if (grant !== 4'b0001) begin fails++; $display("FAIL reset_release got=%b want=0001", grant); end
        go_idle();
    endtask

    task automatic test_single();
        logic t;
        req = 4'b0100;
        cycle();
        tests++; if (grant !== 4'b0100 || busy !== 1'b1) begin fails++; $display("FAIL single_grant got=%b busy=%b want=0100 busy=1", grant, busy); end
        for (int i = 0; i < 19; i++) begin
            t = tone[2];
            cycle();
            tests++; if (speaker !== t) begin fails++; $display("FAIL single_speaker[%0d] got=%b want=%b", i, speaker, t); end
        end
        req = '0;
        cycle();
        tests++; if (grant !== '0 || busy !== 1'b1) begin fails++; $display("FAIL single_drop got=%b busy=%b want=0000 busy=1", grant, busy); end
        for (int i = 1; i < G; i++) begin
            cycle();
            tests++; if (grant !== '0 || busy !== 1'b1 || speaker !== 1'b0) begin fails++; $display("FAIL single_gap[%0d] got=%b/%b/%b want=0000/0/1", i, grant, speaker, busy); end
        end
        cycle();
        tests++; if (busy !== 1'b0 || grant !== '0) begin fails++; $display("FAIL single_idle got busy=%b grant=%b want 0/0000", busy, grant); end
        go_idle();
    endtask

    task automatic test_preempt();
        req = 4'b1000;
        cycle();
        tests++; if (grant !== 4'b1000) begin fails++; $display("FAIL pre_grant got=%b want=1000", grant); end
        repeat (2) cycle();
        req = 4'b1001;
        for (int i = 3; i <= H; i++) begin
            cycle();
            tests++; if (grant !== 4'b1000) begin fails++; $display("FAIL pre_hold[%0d] got=%b want=1000", i, grant); end
        end
        cycle();
        tests++; if (grant !== '0) begin fails++; $display("FAIL pre_switch got=%b want=0000", grant); end
        for (int i = 1; i < G; i++) begin
            cycle();
            tests++; if (grant !== '0 || speaker !== 1'b0) begin fails++; $display("FAIL pre_gap[%0d] got=%b spk=%b want=0000/0", i, grant, speaker); end
        end
        cycle();
        tests++; if (grant !== 4'b0001) begin fails++; $display("FAIL pre_new got=%b want=0001", grant); end
        go_idle();
    endtask

    task automatic test_no_lower_preempt();
        req = 4'b0010;
        cycle();
        req = 4'b0110;
        for (int i = 0; i < 50; i++) begin
            cycle();
            tests++; if (grant !== 4'b0010) begin fails++; $display("FAIL lower_hold[%0d] got=%b want=0010", i, grant); end
        end
        req = 4'b0100;
        for (int i = 0; i < G; i++) begin
            cycle();
            tests++; if (grant !== '0) begin fails++; $display("FAIL lower_gap[%0d] got=%b want=0000", i, grant); end
        end
        cycle();
        tests++; if (grant !== 4'b0100) begin fails++; $display("FAIL lower_next got=%b want=0100", grant); end
        go_idle();
    endtask

    task automatic test_simultaneous();
        req = 4'b1110;
        cycle();
        tests++; if (grant !== 4'b0010) begin fails++; $display("FAIL simul_grant got=%b want=0010", grant); end
        for (int i = 0; i < 40; i++) begin
            req = N'($urandom);
            cycle();
            tests++; if (!$onehot0(grant)) begin fails++; $display("FAIL simul_onehot got=%b want=onehot0", grant); end
        end
        go_idle();
    endtask

    task automatic test_gap_vanish();
        req = 4'b0001;
        cycle();
        req = '0;
        cycle();
        req = 4'b0001;
        cycle();
        req = '0;
        cycle();
        req = 4'b1000;
        cycle();
        tests++; if (grant !== '0) begin fails++; $display("FAIL vanish_gap got=%b want=0000", grant); end
        cycle();
        tests++; if (grant !== 4'b1000) begin fails++; $display("FAIL vanish_grant got=%b want=1000", grant); end
        go_idle();
    endtask

    task automatic test_random();
        logic [N-1:0] prev = '0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(9) == 0) req = N'($urandom);
            cycle();
            tests++;
            if (grant !== m_grant() || speaker !== m_spk || busy !== m_busy) begin
                fails++;
                $display("FAIL random[%0d] got=%b/%b/%b want=%b/%b/%b", i, grant, speaker, busy, m_grant(), m_spk, m_busy);
            end
            tests++;
            if (prev != '0 && grant != '0 && grant !== prev) begin
                fails++;
                $display("FAIL random_direct_switch[%0d] got=%b want=%b or 0000", i, grant, prev);
            end
            prev = grant;
        end
        go_idle();
    endtask

    initial begin
        test_reset();
        test_single();
        test_preempt();
        test_no_lower_preempt();
        test_simultaneous();
        test_gap_vanish();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/siren_arbiter.md
# siren_arbiter

Shares one physical speaker pin among up to N_SRC siren/tone generators (ambulance, police and later sources), each of which produces a square-wave tone on `clk`. Sources raise a request; the arbiter grants the highest-priority requester, enforces a minimum play time before preemption, and inserts a fixed silent gap between any two grants so transitions are audible and click-free. It sits between the tone generators and the board speaker output.

## Interface
- `N_SRC`, default 4: number of sources; index 0 has the highest priority.
- `HOLD_CYCLES`, default 1000: minimum PLAY cycles before a higher-priority source may preempt; must be ≥ 1.
- `GAP_CYCLES`, default 100: silent cycles between grants; must be ≥ 1.
- `clk`  input  1  system clock; the only clock.
- `rst_n`  input  1  reset, asynchronous, active-low.
- `req`  input  N_SRC  per-source play request, level-sensitive, synchronous to `clk`.
- `tone`  input  N_SRC  per-source tone waveform, synchronous to `clk`.
- `grant`  output  N_SRC  one-hot current grant, all-zero when nothing plays; registered.
- `speaker`  output  1  muxed tone, registered.
- `busy`  output  1  high in PLAY or GAP; registered.

## Operation
- States: IDLE, PLAY, GAP. Reset → IDLE, with `grant`=0, `speaker`=0, `busy`=0, and both counters at 0.
- `hold_cnt` is wide enough for HOLD_CYCLES; it saturates at HOLD_CYCLES. `gap_cnt` is wide enough for GAP_CYCLES.
- Priority encode: `win` = one-hot of the lowest set index of `req`.
- IDLE:
  - If `req`≠0: `grant`←`win`, `hold_cnt`←0, go to PLAY.
  - Otherwise stay in IDLE.
- PLAY:
  - `hold_cnt` increments each cycle, saturating.
  - Exit (a): if the granted source's `req` is low, go to GAP immediately, regardless of `hold_cnt`.
  - Exit (b): if a strictly higher-priority `req` is high and `hold_cnt`==HOLD_CYCLES, go to GAP.
  - A lower-priority request never preempts. An equal (own) request keeps PLAY.
  - On entry to GAP: `grant`←0, `gap_cnt`←0.
- GAP:
  - `gap_cnt` increments each cycle.
  - In the cycle where `gap_cnt`==GAP_CYCLES−1, re-arbitrate on the current `req`:
    - `req`≠0 → `grant`←`win`, `hold_cnt`←0, go to PLAY.
    - Otherwise go to IDLE.
  - `req` changes earlier in GAP are ignored. The gap always runs its full length.
- If both exit (a) and exit (b) are true in the same cycle, the result is a single transition to GAP.
- `busy` is registered and equals (next state ≠ IDLE).
- `speaker`:
  - At each edge, `speaker` ← |(`tone` & `grant`) if the current state is PLAY, else 0.
  - This uses the pre-edge `grant`, so `speaker` lags `grant` by one cycle.
  - `speaker` is 0 for the cycle after any grant drops.
- An `rst_n` assertion at any point (mid-PLAY or mid-GAP) forces all outputs and counters to 0 asynchronously. The first arbitration happens at the first rising edge after deassertion.

## Timing
- Request to grant from IDLE: `req` sampled high at edge k → `grant` valid after edge k (1 cycle). First tone bit on `speaker` appears after edge k+1.
- Release to silence: `req[g]` sampled low at edge k → `grant`=0 after edge k. `speaker` is forced 0 after edge k+1.
- Preemption: the earliest switch-out is the edge at which `hold_cnt`==HOLD_CYCLES, i.e. HOLD_CYCLES+1 edges after the grant edge.
- Gap: from the GAP-entry edge to the new grant edge is exactly GAP_CYCLES edges. `grant`=0 for GAP_CYCLES cycles.
- `grant` is never multi-hot, and never changes directly from one source to another without ≥ GAP_CYCLES zero cycles in between.

## Test plan
Bench uses N_SRC=4, HOLD_CYCLES=8, GAP_CYCLES=4, and `tone[i]` = a divider of `clk` by 2(i+1).
- Reset mid-PLAY: hold `req`=4'b0001, pulse `rst_n` low for 3 ns mid-PLAY → `grant`, `speaker`, `busy` go to 0 immediately. Release with `req`=4'b0001 held → `grant`=4'b0001 after the first edge.
- Single request: `req`=4'b0100 held for 20 cycles from IDLE, then dropped:
  - `grant`=4'b0100 one cycle after `req` rises.
  - `speaker` follows `tone[2]` delayed one cycle.
  - After the drop, `grant`=0 next cycle and `busy` stays high for 4 cycles, then IDLE.
- Preemption honoring hold: `req[3]` granted; `req[0]` rises 2 cycles later →
  - `grant`=4'b1000 until `hold_cnt` reaches 8.
  - Then 4 cycles of `grant`=0 and `speaker`=0.
  - Then `grant`=4'b0001.
- No preemption by lower priority: `req[1]` granted, `req[2]` raised → `grant` stays 4'b0010 for 50 cycles. After `req[1]` drops, gap of 4, then `grant`=4'b0100.
- Simultaneous requests: `req`=4'b1110 on one edge from IDLE → `grant`=4'b0010 only. Onehot check passes every cycle.
- Request vanishing during GAP: drop all `req` in GAP cycle 2 and re-raise `req[3]` in cycle 3 → `grant`=4'b1000 exactly 4 cycles after GAP entry.
